raster_tile_walker: RTL

- Sequencer in front of the rasterizer's per-pixel evaluation pipeline.
- Accepts one triangle setup record at a time and walks its screen bounding box in row-major order.
- Issues one (x, y) plus the held setup record per accepted pixel beat.
- After the last beat it waits for the downstream pipeline to drain, then pulses done so the triangle feeder can send the next triangle.

---
 rtl/color_pkg.sv | 4 +
 rtl/math_pkg.sv | 4 +
 rtl/rast_pkg.sv | 42 ++++
 rtl/raster_tile_walker.sv | 108 ++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Colour formats shared across the raster pipeline.
package color_pkg;
  typedef logic [11:0] color12_t;
endpackage

// File: rtl/math_pkg.sv
// Fixed-point numeric types shared across the raster pipeline.
package math_pkg;
  typedef logic signed [31:0] q16_16_t;
endpackage

// File: rtl/rast_pkg.sv
// Triangle setup record and walker state shared by the rasterizer front end.
package rast_pkg;
  import math_pkg::*;
  import color_pkg::*;

  localparam int unsigned SUBPIXEL_BITS  = 4;
  localparam int unsigned DENOM_INV_BITS = 36;
  localparam int unsigned BBOX_W         = 16;
  localparam int unsigned DEPTH_W        = 24;

  typedef struct packed {
    q16_16_t                              v0_x;
    q16_16_t                              v0_y;
    logic signed [BBOX_W+SUBPIXEL_BITS-1:0] e0_x;
    logic signed [BBOX_W+SUBPIXEL_BITS-1:0] e0_y;
    logic signed [BBOX_W+SUBPIXEL_BITS-1:0] e1_x;
    logic signed [BBOX_W+SUBPIXEL_BITS-1:0] e1_y;
    logic signed [DENOM_INV_BITS-1:0]     denom_inv;
    logic [BBOX_W-1:0]                    bbox_min_x;
    logic [BBOX_W-1:0]                    bbox_min_y;
    logic [BBOX_W-1:0]                    bbox_max_x;
    logic [BBOX_W-1:0]                    bbox_max_y;
    color12_t                             color0;
    color12_t                             color1;
    color12_t                             color2;
    logic [DEPTH_W-1:0]                   depth0;
    logic [DEPTH_W-1:0]                   depth1;
    logic [DEPTH_W-1:0]                   depth2;
  } tri_setup_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_DRAIN,
    S_DONE
  } walker_state_t;

  function automatic logic [BBOX_W-1:0] clamp_max(input logic [BBOX_W-1:0] v,
                                                   input int unsigned lim);
    return (v > BBOX_W'(lim)) ? BBOX_W'(lim) : v;
  endfunction
endpackage

// File: rtl/raster_tile_walker.sv
// Walks a triangle's clamped screen bounding box row-major, one pixel beat per
// accepted handshake, then waits for the evaluator to drain before signalling done.
module raster_tile_walker
  import rast_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  tri_setup_t       tri_in,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic             abort,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output tri_setup_t       pix_tri,
  output logic             pix_valid,
  input  logic             pix_ready,
  input  logic             eval_busy,
  output logic             tri_done,
  output logic [16:0]      tri_pixels
);

  walker_state_t state, state_n;

  logic [BBOX_W-1:0] clamp_x, clamp_y;
  logic              empty, accept, xfer, last_col, last_row;
  logic [XW-1:0]     min_x_q, max_x_q;
  logic [YW-1:0]     max_y_q;
  logic [16:0]       cnt;

  // Empty test runs on full bbox width so off-screen mins never alias on-screen.
  always_comb begin
    clamp_x = clamp_max(tri_in.bbox_max_x, WIDTH - 1);
    clamp_y = clamp_max(tri_in.bbox_max_y, HEIGHT - 1);
    empty   = (tri_in.bbox_min_x > clamp_x) ||
              (tri_in.bbox_min_y > clamp_y) ||
              (tri_in.denom_inv == '0);
  end

  assign tri_ready = (state == S_IDLE);
  assign pix_valid = (state == S_WALK);
  assign tri_done  = (state == S_DONE);
  assign accept    = tri_valid && tri_ready;
  assign xfer      = pix_valid && pix_ready;
  assign last_col  = (pix_x == max_x_q);
  assign last_row  = (pix_y == max_y_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = empty ? S_DRAIN : S_WALK;
      S_WALK: begin
        if (abort)                           state_n = S_IDLE;
        else if (xfer && last_col && last_row) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)           state_n = S_IDLE;
        else if (!eval_busy) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tri    <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
      cnt        <= '0;
      tri_pixels <= '0;
    end else begin
      if (accept) begin
        pix_tri <= tri_in;
        pix_x   <= tri_in.bbox_min_x[XW-1:0];
        pix_y   <= tri_in.bbox_min_y[YW-1:0];
        min_x_q <= tri_in.bbox_min_x[XW-1:0];
        max_x_q <= clamp_x[XW-1:0];
        max_y_q <= clamp_y[YW-1:0];
        cnt     <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
        // At the final pixel the coordinates stay put; the FSM leaves WALK instead.
        if (!last_col) begin
          pix_x <= pix_x + 1'b1;
        end else if (!last_row) begin
          pix_x <= min_x_q;
          pix_y <= pix_y + 1'b1;
        end
      end
      if (state == S_DRAIN && !eval_busy && !abort)
        tri_pixels <= cnt;
    end
  end

endmodule
